// File: rtl/dlsc_dcm_clkgen_ctrl_pkg.sv
// Shared definitions for the clkgen retune sequencer: CSR map, field positions, FSM and error codes.
package dlsc_dcm_clkgen_ctrl_pkg;

   // Register word indices; byte address = BASE + 4*index
   localparam logic [3:0] REG_CONTROL  = 4'd0;
   localparam logic [3:0] REG_STATUS   = 4'd1;
   localparam logic [3:0] REG_MULTIPLY = 4'd4;
   localparam logic [3:0] REG_DIVIDE   = 4'd5;

   localparam int STATUS_READY  = 0;
   localparam int STATUS_ST_LSB = 12;
   localparam int STATUS_ST_MSB = 14;

   localparam int CONTROL_ENABLE       = 0;
   localparam int CONTROL_USE_DEFAULTS = 1;
   localparam int CONTROL_IGNORE_STOP  = 2;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_CHECK,
      ST_DIS_WR,
      ST_DIS_POLL,
      ST_MUL_WR,
      ST_DIV_WR,
      ST_EN_WR,
      ST_EN_POLL,
      ST_ABORT_WR,
      ST_DONE
   } state_t;

   typedef enum logic [1:0] {
      ERR_OK       = 2'd0,
      ERR_CFG      = 2'd1,
      ERR_DIS_TMO  = 2'd2,
      ERR_LOCK_TMO = 2'd3
   } err_t;

   // M/D pair is unusable when M is zero or (M+1)/(D+1) exceeds the DCM ratio limit
   function automatic logic md_cfg_bad(input logic [7:0] mult, input logic [7:0] div,
                                       input int unsigned md_max);
      logic [16:0] lhs;
      logic [16:0] rhs;
      lhs = 17'(mult) + 17'd1;
      rhs = 17'(md_max) * (17'(div) + 17'd1);
      return (mult == 8'd0) || (lhs > rhs);
   endfunction

endpackage

// File: rtl/dlsc_apb_mst_xfer.sv
// Single-transfer APB master engine: one req launches setup+access, ack pulses after PREADY.
module dlsc_apb_mst_xfer #(
   parameter int unsigned ADDR = 32
) (
   input  logic            apb_clk,
   input  logic            apb_rst_n,
   input  logic            req,
   input  logic            wr,
   input  logic [ADDR-1:0] addr,
   input  logic [31:0]     wdata,
   output logic            ack,
   output logic [31:0]     rdata,
   output logic [ADDR-1:0] apb_addr,
   output logic            apb_sel,
   output logic            apb_enable,
   output logic            apb_write,
   output logic [31:0]     apb_wdata,
   output logic [3:0]      apb_strb,
   input  logic            apb_ready,
   input  logic [31:0]     apb_rdata
);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge apb_clk) begin
      if (!apb_rst_n) begin
         ack        <= 1'b0;
         rdata      <= '0;
         apb_addr   <= '0;
         apb_sel    <= 1'b0;
         apb_enable <= 1'b0;
         apb_write  <= 1'b0;
         apb_wdata  <= '0;
         apb_strb   <= 4'h0;
      end else begin
         ack <= 1'b0;
         if (!apb_sel) begin
            if (req) begin
               apb_sel   <= 1'b1;
               apb_addr  <= addr;
               apb_write <= wr;
               apb_wdata <= wr ? wdata : 32'd0;
               apb_strb  <= wr ? 4'hF : 4'h0;
            end
         end else if (!apb_enable) begin
            apb_enable <= 1'b1;
         end else if (apb_ready) begin
            // Bus goes idle for at least one cycle after every completed access
            apb_sel    <= 1'b0;
            apb_enable <= 1'b0;
            ack        <= 1'b1;
            rdata      <= apb_rdata;
         end
      end
   end

endmodule

// File: rtl/dlsc_dcm_clkgen_ctrl.sv
// Retune sequencer for dlsc_dcm_clkgen: validates an M/D request, then disables, reloads and
// re-enables the DCM over APB, polling STATUS with a gap and a per-phase timeout.
module dlsc_dcm_clkgen_ctrl
   import dlsc_dcm_clkgen_ctrl_pkg::*;
#(
   parameter int unsigned     ADDR        = 32,
   parameter logic [ADDR-1:0] BASE        = '0,
   parameter int unsigned     CLK_MD_MAX  = 4,
   parameter bit              IGNORE_STOP = 1'b0,
   parameter int unsigned     POLL_GAP    = 15,
   parameter int unsigned     TIMEOUT_W   = 20
) (
   input  logic            apb_clk,
   input  logic            apb_rst_n,
   input  logic            cfg_valid,
   output logic            cfg_ready,
   input  logic [7:0]      cfg_mult,
   input  logic [7:0]      cfg_div,
   output logic            busy,
   output logic            done_valid,
   output logic [1:0]      done_err,
   output logic [ADDR-1:0] apb_addr,
   output logic            apb_sel,
   output logic            apb_enable,
   output logic            apb_write,
   output logic [31:0]     apb_wdata,
   output logic [3:0]      apb_strb,
   input  logic            apb_ready,
   input  logic [31:0]     apb_rdata
);

   state_t                 state;
   logic [7:0]             mult_r;
   logic [7:0]             div_r;
   logic                   xfer_req;
   logic                   xfer_wr;
   logic [ADDR-1:0]        xfer_addr;
   logic [31:0]            xfer_wdata;
   logic                   xfer_ack;
   logic [31:0]            xfer_rdata;
   logic                   issued;
   logic                   tmo_seen;
   logic [7:0]             gap_cnt;
   logic [TIMEOUT_W-1:0]   tmo_cnt;

   logic [3:0]             wr_idx;
   logic [31:0]            wr_data;
   logic [31:0]            en_word;
   logic                   in_poll;
   logic                   tmo_hit;
   logic                   poll_ok;
   logic                   unused_rdata;

   dlsc_apb_mst_xfer #(
      .ADDR       (ADDR)
   ) u_xfer (
      .apb_clk    (apb_clk),
      .apb_rst_n  (apb_rst_n),
      .req        (xfer_req),
      .wr         (xfer_wr),
      .addr       (xfer_addr),
      .wdata      (xfer_wdata),
      .ack        (xfer_ack),
      .rdata      (xfer_rdata),
      .apb_addr   (apb_addr),
      .apb_sel    (apb_sel),
      .apb_enable (apb_enable),
      .apb_write  (apb_write),
      .apb_wdata  (apb_wdata),
      .apb_strb   (apb_strb),
      .apb_ready  (apb_ready),
      .apb_rdata  (apb_rdata)
   );

   assign unused_rdata = ^{xfer_rdata[31:STATUS_ST_MSB+1], xfer_rdata[STATUS_ST_LSB-1:1]};

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      en_word                       = '0;
      en_word[CONTROL_ENABLE]       = 1'b1;
      en_word[CONTROL_USE_DEFAULTS] = 1'b0;
      en_word[CONTROL_IGNORE_STOP]  = IGNORE_STOP;

      wr_idx  = REG_CONTROL;
      wr_data = '0;
      case (state)
         ST_MUL_WR: begin wr_idx = REG_MULTIPLY; wr_data = {24'd0, mult_r}; end
         ST_DIV_WR: begin wr_idx = REG_DIVIDE;   wr_data = {24'd0, div_r};  end
         ST_EN_WR:  wr_data = en_word;
         default:   ;
      endcase

      in_poll = (state == ST_DIS_POLL) || (state == ST_EN_POLL);
      tmo_hit = &tmo_cnt;
      if (state == ST_EN_POLL) begin
         poll_ok = xfer_rdata[STATUS_READY];
      end else begin
         poll_ok = !xfer_rdata[STATUS_READY] &&
                   (xfer_rdata[STATUS_ST_MSB:STATUS_ST_LSB] == 3'd0);
      end
   end

   always_ff @(posedge apb_clk) begin
      if (!apb_rst_n) begin
         state      <= ST_IDLE;
         cfg_ready  <= 1'b1;
         busy       <= 1'b0;
         done_valid <= 1'b0;
         done_err   <= ERR_OK;
         mult_r     <= '0;
         div_r      <= '0;
         xfer_req   <= 1'b0;
         xfer_wr    <= 1'b0;
         xfer_addr  <= '0;
         xfer_wdata <= '0;
         issued     <= 1'b0;
         tmo_seen   <= 1'b0;
         gap_cnt    <= '0;
         tmo_cnt    <= '0;
      end else begin
         xfer_req   <= 1'b0;
         done_valid <= 1'b0;
         if (in_poll && !tmo_hit) tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);

         case (state)
            ST_IDLE: begin
               if (cfg_valid) begin
                  mult_r    <= cfg_mult;
                  div_r     <= cfg_div;
                  cfg_ready <= 1'b0;
                  busy      <= 1'b1;
                  state     <= ST_CHECK;
               end
            end

            ST_CHECK: begin
               if (md_cfg_bad(mult_r, div_r, CLK_MD_MAX)) begin
                  done_err   <= ERR_CFG;
                  done_valid <= 1'b1;
                  state      <= ST_DONE;
               end else begin
                  state <= ST_DIS_WR;
               end
            end

            ST_DIS_WR, ST_MUL_WR, ST_DIV_WR, ST_EN_WR, ST_ABORT_WR: begin
               if (!issued) begin
                  xfer_req   <= 1'b1;
                  xfer_wr    <= 1'b1;
                  xfer_addr  <= BASE + ADDR'({wr_idx, 2'b00});
                  xfer_wdata <= wr_data;
                  issued     <= 1'b1;
               end else if (xfer_ack) begin
                  issued <= 1'b0;
                  case (state)
                     ST_MUL_WR: state <= ST_DIV_WR;
                     ST_DIV_WR: state <= ST_EN_WR;
                     ST_ABORT_WR: begin
                        done_err   <= ERR_LOCK_TMO;
                        done_valid <= 1'b1;
                        state      <= ST_DONE;
                     end
                     default: begin
                        // Both poll phases start with a fresh timeout and an immediate read
                        state    <= (state == ST_DIS_WR) ? ST_DIS_POLL : ST_EN_POLL;
                        tmo_cnt  <= '0;
                        tmo_seen <= 1'b0;
                        gap_cnt  <= '0;
                     end
                  endcase
               end
            end

            ST_DIS_POLL, ST_EN_POLL: begin
               if (issued) begin
                  if (xfer_ack) begin
                     issued <= 1'b0;
                     if (poll_ok && !tmo_seen) begin
                        if (state == ST_DIS_POLL) begin
                           state <= ST_MUL_WR;
                        end else begin
                           done_err   <= ERR_OK;
                           done_valid <= 1'b1;
                           state      <= ST_DONE;
                        end
                     end else if (tmo_hit) begin
                        if (state == ST_DIS_POLL) begin
                           done_err   <= ERR_DIS_TMO;
                           done_valid <= 1'b1;
                           state      <= ST_DONE;
                        end else begin
                           state <= ST_ABORT_WR;
                        end
                     end else begin
                        gap_cnt <= 8'(POLL_GAP);
                     end
                  end else if (tmo_hit) begin
                     // Read still in flight at timeout: let it finish, ignore what it returns
                     tmo_seen <= 1'b1;
                  end
               end else if (tmo_hit) begin
                  if (state == ST_DIS_POLL) begin
                     done_err   <= ERR_DIS_TMO;
                     done_valid <= 1'b1;
                     state      <= ST_DONE;
                  end else begin
                     state <= ST_ABORT_WR;
                  end
               end else if (gap_cnt != 8'd0) begin
                  gap_cnt <= gap_cnt - 8'd1;
               end else begin
                  xfer_req   <= 1'b1;
                  xfer_wr    <= 1'b0;
                  xfer_addr  <= BASE + ADDR'({REG_STATUS, 2'b00});
                  xfer_wdata <= '0;
                  issued     <= 1'b1;
               end
            end

            ST_DONE: begin
               state     <= ST_IDLE;
               busy      <= 1'b0;
               cfg_ready <= 1'b1;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dlsc_dcm_clkgen_ctrl.sv
// Directed bench for dlsc_dcm_clkgen_ctrl against a small behavioural clkgen CSR/DCM model.
module tb_dlsc_dcm_clkgen_ctrl;

   localparam int ADDR = 32;

   logic            apb_clk = 1'b0;
   logic            apb_rst_n = 1'b0;
   logic            cfg_valid = 1'b0;
   logic            cfg_ready;
   logic [7:0]      cfg_mult = 8'd0;
   logic [7:0]      cfg_div = 8'd0;
   logic            busy;
   logic            done_valid;
   logic [1:0]      done_err;
   logic [ADDR-1:0] apb_addr;
   logic            apb_sel;
   logic            apb_enable;
   logic            apb_write;
   logic [31:0]     apb_wdata;
   logic [3:0]      apb_strb;
   logic            apb_ready;
   logic [31:0]     apb_rdata;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int sel_cycles = 0;
   int proto_viol = 0;

   always #5 apb_clk = ~apb_clk;
   always @(posedge apb_clk) cyc <= cyc + 1;

   dlsc_dcm_clkgen_ctrl #(
      .ADDR        (ADDR),
      .BASE        (32'h0),
      .CLK_MD_MAX  (4),
      .IGNORE_STOP (1'b0),
      .POLL_GAP    (3),
      .TIMEOUT_W   (8)
   ) dut (
      .apb_clk    (apb_clk),
      .apb_rst_n  (apb_rst_n),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_mult   (cfg_mult),
      .cfg_div    (cfg_div),
      .busy       (busy),
      .done_valid (done_valid),
      .done_err   (done_err),
      .apb_addr   (apb_addr),
      .apb_sel    (apb_sel),
      .apb_enable (apb_enable),
      .apb_write  (apb_write),
      .apb_wdata  (apb_wdata),
      .apb_strb   (apb_strb),
      .apb_ready  (apb_ready),
      .apb_rdata  (apb_rdata)
   );

   // Clkgen model: one wait state per access; disable takes a few cycles, lock ~10 cycles
   logic [31:0] m_control, m_multiply, m_divide;
   logic        m_ready;
   logic [2:0]  m_st;
   int          m_st_cnt, m_lock_cnt;
   logic        acc_r;
   bit          hold_busy = 1'b0;
   bit          hold_unlock = 1'b0;
   logic [63:0] wr_log[$];

   assign apb_ready = apb_sel && apb_enable && acc_r;

   always_comb begin
      apb_rdata = 32'd0;
      case (apb_addr)
         32'h00:  apb_rdata = m_control;
         32'h04:  apb_rdata = {17'd0, m_st, 11'd0, m_ready};
         32'h10:  apb_rdata = m_multiply;
         32'h14:  apb_rdata = m_divide;
         default: apb_rdata = 32'd0;
      endcase
   end

   always @(posedge apb_clk) begin
      if (!apb_rst_n) begin
         m_control  <= 32'd0;
         m_multiply <= 32'd0;
         m_divide   <= 32'd0;
         m_ready    <= 1'b0;
         m_st       <= 3'd0;
         m_st_cnt   <= 0;
         m_lock_cnt <= 0;
         acc_r      <= 1'b0;
      end else begin
         acc_r <= apb_sel && apb_enable && !apb_ready;
         if (m_st != 3'd0 && !hold_busy) begin
            if (m_st_cnt <= 1) m_st <= 3'd0;
            else m_st_cnt <= m_st_cnt - 1;
         end
         if (m_lock_cnt > 0) begin
            m_lock_cnt <= m_lock_cnt - 1;
            if (m_lock_cnt == 1 && !hold_unlock) m_ready <= 1'b1;
         end
         if (apb_ready && apb_write) begin
            wr_log.push_back({apb_addr, apb_wdata});
            case (apb_addr)
               32'h00: begin
                  m_control <= apb_wdata;
                  if (apb_wdata[0]) begin
                     m_lock_cnt <= 10;
                  end else begin
                     m_ready    <= 1'b0;
                     m_lock_cnt <= 0;
                     m_st       <= 3'd2;
                     m_st_cnt   <= 6;
                  end
               end
               32'h10:  m_multiply <= apb_wdata;
               32'h14:  m_divide   <= apb_wdata;
               default: ;
            endcase
         end
      end
   end

   always @(posedge apb_clk) begin
      if (apb_rst_n) begin
         if (apb_sel) sel_cycles <= sel_cycles + 1;
         if ((apb_enable && !apb_sel) ||
             (apb_sel && apb_write && apb_strb != 4'hF) ||
             (apb_sel && !apb_write && apb_strb != 4'h0))
            proto_viol <= proto_viol + 1;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic do_req(input logic [7:0] m, input logic [7:0] d, input bit keep,
                         output int acc_cyc);
      int waited;
      waited = 0;
      @(negedge apb_clk);
      while (!cfg_ready && waited < 100) begin
         @(negedge apb_clk);
         waited++;
      end
      if (!cfg_ready) check("req_ready_timeout", 64'd0, 64'd1);
      cfg_valid = 1'b1;
      cfg_mult  = m;
      cfg_div   = d;
      @(posedge apb_clk);
      #1;
      acc_cyc = cyc;
      if (!keep) begin
         @(negedge apb_clk);
         cfg_valid = 1'b0;
      end
   endtask

   // Waits for the done pulse, then checks the following cycle is idle and accepting
   task automatic wait_done(input string tag, input int budget, output logic [1:0] err,
                            output int dcyc);
      bit seen;
      seen = 1'b0;
      err  = 2'd0;
      dcyc = 0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge apb_clk);
         if (done_valid) begin
            seen = 1'b1;
            err  = done_err;
            dcyc = cyc;
         end
      end
      if (!seen) begin
         check({tag, "_done_timeout"}, 64'd0, 64'd1);
      end else begin
         @(negedge apb_clk);
         check({tag, "_pulse_1cyc"}, 64'(done_valid), 64'd0);
         check({tag, "_busy_after"}, 64'(busy), 64'd0);
         check({tag, "_ready_after"}, 64'(cfg_ready), 64'd1);
      end
   endtask

   logic [7:0]  bad_m[4] = '{8'd0, 8'd19, 8'd16, 8'd0};
   logic [7:0]  bad_d[4] = '{8'd0, 8'd3,  8'd3,  8'd5};

   initial begin
      int          acc, dc, dc2, sel_before, waited;
      logic [1:0]  err;
      bit          found;

      repeat (3) @(negedge apb_clk);
      check("rst_cfg_ready", 64'(cfg_ready), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done_valid", 64'(done_valid), 64'd0);
      check("rst_done_err", 64'(done_err), 64'd0);
      check("rst_sel_enable", 64'({apb_sel, apb_enable}), 64'd0);
      check("rst_write_strb", 64'({apb_write, apb_strb}), 64'd0);
      check("rst_addr_wdata", {apb_addr, apb_wdata}, 64'd0);
      apb_rst_n = 1'b1;

      // Nominal retune 8/4
      wr_log.delete();
      do_req(8'd7, 8'd3, 1'b0, acc);
      wait_done("t1", 2000, err, dc);
      check("t1_err", 64'(err), 64'd0);
      check("t1_nwr", 64'(wr_log.size()), 64'd4);
      check("t1_wr0", wr_log[0], {32'h00, 32'd0});
      check("t1_wr1", wr_log[1], {32'h10, 32'd7});
      check("t1_wr2", wr_log[2], {32'h14, 32'd3});
      check("t1_wr3", wr_log[3], {32'h00, 32'd1});
      check("t1_locked", 64'(m_ready), 64'd1);

      // Rejected configurations: quick error, no bus activity
      foreach (bad_m[i]) begin
         sel_before = sel_cycles;
         do_req(bad_m[i], bad_d[i], 1'b0, acc);
         wait_done($sformatf("t2_%0d", i), 20, err, dc);
         check($sformatf("t2_%0d_err", i), 64'(err), 64'd1);
         check($sformatf("t2_%0d_lat", i), 64'((dc - acc) <= 3), 64'd1);
         check($sformatf("t2_%0d_nosel", i), 64'(sel_cycles), 64'(sel_before));
      end

      // Ratio exactly at the limit is accepted
      wr_log.delete();
      do_req(8'd15, 8'd3, 1'b0, acc);
      wait_done("t2b", 2000, err, dc);
      check("t2b_err", 64'(err), 64'd0);
      check("t2b_mult", 64'(m_multiply), 64'd15);

      // DCM never locks: lock timeout, then CONTROL cleared
      hold_unlock = 1'b1;
      wr_log.delete();
      do_req(8'd7, 8'd3, 1'b0, acc);
      wait_done("t3", 3000, err, dc);
      check("t3_err", 64'(err), 64'd3);
      check("t3_long", 64'((dc - acc) > 255), 64'd1);
      check("t3_nwr", 64'(wr_log.size()), 64'd5);
      check("t3_wr3", wr_log[3], {32'h00, 32'd1});
      check("t3_abort", wr_log[4], {32'h00, 32'd0});
      hold_unlock = 1'b0;

      // Disable never completes: disable timeout, no M/D writes
      hold_busy = 1'b1;
      wr_log.delete();
      do_req(8'd7, 8'd3, 1'b0, acc);
      wait_done("t4", 3000, err, dc);
      check("t4_err", 64'(err), 64'd2);
      check("t4_nwr", 64'(wr_log.size()), 64'd1);
      check("t4_wr0", wr_log[0], {32'h00, 32'd0});
      hold_busy = 1'b0;
      repeat (10) @(negedge apb_clk);

      // Reset during MULTIPLY access phase
      do_req(8'd7, 8'd3, 1'b0, acc);
      found  = 1'b0;
      waited = 0;
      while (!found && waited < 500) begin
         if (apb_sel && apb_enable && apb_addr == 32'h10) found = 1'b1;
         else begin
            @(negedge apb_clk);
            waited++;
         end
      end
      check("t5_reach_mul", 64'(found), 64'd1);
      apb_rst_n = 1'b0;
      @(negedge apb_clk);
      check("t5_sel_enable", 64'({apb_sel, apb_enable}), 64'd0);
      check("t5_cfg_ready", 64'(cfg_ready), 64'd1);
      check("t5_busy", 64'(busy), 64'd0);
      apb_rst_n = 1'b1;
      repeat (2) @(negedge apb_clk);

      // Request held valid with M/D changed mid-run: ignored until done
      wr_log.delete();
      do_req(8'd7, 8'd3, 1'b1, acc);
      repeat (5) @(negedge apb_clk);
      cfg_mult = 8'd19;
      cfg_div  = 8'd3;
      wait_done("t6a", 2000, err, dc);
      check("t6a_err", 64'(err), 64'd0);
      check("t6a_wr1", wr_log[1], {32'h10, 32'd7});
      wait_done("t6b", 20, err, dc2);
      cfg_valid = 1'b0;
      check("t6b_err", 64'(err), 64'd1);
      check("t6b_gap", 64'(dc2 - dc), 64'd3);
      check("t6_mult_kept", 64'(m_multiply), 64'd7);

      check("proto_viol", 64'(proto_viol), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no summary, expected end of run");
      $fatal(1);
   end

endmodule
